// File: rtl/gray_rgb565_expander_pkg.sv
// ============================================================================
// gray_rgb565_expander_pkg : shared widths and FSM encoding for the expander
// Rev 1.0
// ============================================================================
`default_nettype none

package gray_rgb565_expander_pkg;

  localparam int unsigned c_PIX_W  = 8;
  localparam int unsigned c_RGB_W  = 16;
  localparam int unsigned c_WORD_W = 32;
  localparam int unsigned c_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/gray_to_rgb565_pixel.sv
// ============================================================================
// gray_to_rgb565_pixel : replicates one 8-bit gray level into an RGB565 pixel
// Rev 1.0
// ============================================================================
`default_nettype none

module gray_to_rgb565_pixel
  import gray_rgb565_expander_pkg::*;
#(
  parameter bit SWAP_BYTES = 1'b1
) (
  input  logic [c_PIX_W-1:0] gray,
  output logic [c_RGB_W-1:0] rgb
);

  logic [c_RGB_W-1:0] pix;

  assign pix = {gray[7:3], gray[7:2], gray[7:3]};

  // Swapped form matches the byte order the grayscale converter reads from memory
  generate
    if (SWAP_BYTES) begin : g_swap
      assign rgb = {pix[7:0], pix[15:8]};
    end else begin : g_native
      assign rgb = pix;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/gray_rgb565_expander.sv
// ============================================================================
// gray_rgb565_expander : four gray pixels in, two RGB565 output words out
// Rev 1.0
// ============================================================================
`default_nettype none

module gray_rgb565_expander
  import gray_rgb565_expander_pkg::*;
#(
  parameter bit SWAP_BYTES = 1'b1
) (
  input  logic                clock,
  input  logic                nReset,
  input  logic                clear,
  input  logic                inValid,
  input  logic [c_WORD_W-1:0] inData,
  input  logic                inLast,
  output logic                inReady,
  output logic                outValid,
  output logic [c_WORD_W-1:0] outData,
  output logic                outLast,
  input  logic                outReady,
  output logic [c_CNT_W-1:0]  wordCount
);

  state_t              state_q, state_d;
  logic [c_WORD_W-1:0] hold_q, hold_d;
  logic                last_q, last_d;
  logic [c_CNT_W-1:0]  count_q, count_d;

  logic               in_fire;
  logic               out_fire;
  logic [c_PIX_W-1:0] pix_lo;
  logic [c_PIX_W-1:0] pix_hi;
  logic [c_RGB_W-1:0] rgb_lo;
  logic [c_RGB_W-1:0] rgb_hi;

  gray_to_rgb565_pixel #(.SWAP_BYTES(SWAP_BYTES)) u_pix_lo (
    .gray (pix_lo),
    .rgb  (rgb_lo)
  );

  gray_to_rgb565_pixel #(.SWAP_BYTES(SWAP_BYTES)) u_pix_hi (
    .gray (pix_hi),
    .rgb  (rgb_hi)
  );

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    last_d   = last_q;
    count_d  = count_q;
    inReady  = 1'b0;
    outValid = 1'b0;
    outLast  = 1'b0;
    pix_lo   = hold_q[7:0];
    pix_hi   = hold_q[15:8];

    case (state_q)
      ST_EMPTY:  inReady = 1'b1;
      ST_FIRST:  outValid = 1'b1;
      ST_SECOND: begin
        outValid = 1'b1;
        outLast  = last_q;
        inReady  = outReady;
        pix_lo   = hold_q[23:16];
        pix_hi   = hold_q[31:24];
      end
      default: ;
    endcase

    in_fire  = inValid & inReady;
    out_fire = outValid & outReady;
    outData  = outValid ? {rgb_hi, rgb_lo} : '0;

    case (state_q)
      ST_EMPTY:  if (in_fire) state_d = ST_FIRST;
      ST_FIRST:  if (out_fire) state_d = ST_SECOND;
      // inReady follows outReady here, so an input can only land alongside an output
      ST_SECOND: if (out_fire) state_d = in_fire ? ST_FIRST : ST_EMPTY;
      default:   state_d = ST_EMPTY;
    endcase

    if (in_fire) begin
      hold_d = inData;
      last_d = inLast;
    end

    if (out_fire) begin
      count_d = outLast ? '0 : count_q + 16'd1;
    end

    if (clear) begin
      state_d = ST_EMPTY;
      hold_d  = '0;
      last_d  = 1'b0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_EMPTY;
      hold_q  <= '0;
      last_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign wordCount = count_q;

endmodule

`default_nettype wire
